// File: rtl/duty_slew_pkg.sv
// rtl/duty_slew_pkg.sv - shared channel state, duty limits and target clamp for duty_slew
package duty_slew_pkg;

    typedef enum logic {
        TRACK = 1'b0,
        DEAD  = 1'b1
    } ch_state_t;

    localparam logic signed [11:0] DUTY_MAX = 12'sd2047;
    localparam logic signed [11:0] DUTY_MIN = -12'sd2047;

    // -2048 has no positive mirror, so it is pulled in to keep the duty range symmetric
    function automatic logic signed [11:0] clamp_duty(input logic signed [11:0] v);
        if (v < DUTY_MIN) begin
            return DUTY_MIN;
        end
        if (v > DUTY_MAX) begin
            return DUTY_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/duty_ramp_ch.sv
// rtl/duty_ramp_ch.sv - one wheel channel: clamp, slew toward target, dead time on reversal
module duty_ramp_ch
    import duty_slew_pkg::*;
#(
    parameter int STEP     = 8,
    parameter int DEAD_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        estop,
    input  logic [11:0] tgt,
    output logic [11:0] duty,
    output logic        settled
);

    ch_state_t          state;
    ch_state_t          state_nxt;
    logic [15:0]        cnt;
    logic [15:0]        cnt_nxt;
    logic [11:0]        duty_nxt;

    logic signed [11:0] tgt_c;
    logic signed [11:0] duty_s;
    logic signed [11:0] eff;
    logic               reversing;
    logic signed [12:0] diff;
    logic signed [12:0] mag;
    logic signed [12:0] step_s;
    logic signed [12:0] delta;
    logic signed [12:0] sum;

    assign tgt_c     = clamp_duty($signed(tgt));
    assign duty_s    = $signed(duty);
    // a reversal must pass through zero first, so aim at zero while signs disagree
    assign reversing = (duty_s != 12'sd0) && (tgt_c != 12'sd0) && (duty_s[11] != tgt_c[11]);
    assign eff       = reversing ? 12'sd0 : tgt_c;
    assign diff      = {eff[11], eff} - {duty_s[11], duty_s};
    assign mag       = diff[12] ? -diff : diff;
    assign step_s    = 13'(STEP);
    assign delta     = (mag > step_s) ? (diff[12] ? -step_s : step_s) : diff;
    assign sum       = {duty_s[11], duty_s} + delta;

    assign settled   = (state == TRACK) && (duty_s == tgt_c);

    // state, dead counter and duty registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TRACK;
            cnt   <= 16'd0;
            duty  <= 12'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            duty  <= duty_nxt;
        end
    end

    // next-state: estop wins, DEAD counts down at zero duty, TRACK slews on ticks
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        duty_nxt  = duty;
        if (estop) begin
            state_nxt = TRACK;
            cnt_nxt   = 16'd0;
            duty_nxt  = 12'd0;
        end else begin
            case (state)
                TRACK: begin
                    if (tick) begin
                        duty_nxt = sum[11:0];
                        if (reversing && (sum == 13'sd0)) begin
                            state_nxt = DEAD;
                            cnt_nxt   = 16'(DEAD_CYC - 1);
                        end
                    end
                end
                DEAD: begin
                    duty_nxt = 12'd0;
                    if (cnt == 16'd0) begin
                        state_nxt = TRACK;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                default: begin
                    state_nxt = TRACK;
                    cnt_nxt   = 16'd0;
                    duty_nxt  = 12'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/duty_slew.sv
// rtl/duty_slew.sv - two-wheel duty slew limiter with shared ramp prescaler
module duty_slew
    import duty_slew_pkg::*;
#(
    parameter int RAMP_DIV = 64,
    parameter int STEP     = 8,
    parameter int DEAD_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_tgt,
    input  logic [11:0] rght_tgt,
    input  logic        estop,
    output logic [11:0] lft_duty,
    output logic [11:0] rght_duty,
    output logic        lft_settled,
    output logic        rght_settled
);

    localparam int PW = $clog2(RAMP_DIV);

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PW'(RAMP_DIV - 1));

    // shared prescaler, free-running through estop so ramp timing never shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    duty_ramp_ch #(
        .STEP     (STEP),
        .DEAD_CYC (DEAD_CYC)
    ) u_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .estop   (estop),
        .tgt     (lft_tgt),
        .duty    (lft_duty),
        .settled (lft_settled)
    );

    duty_ramp_ch #(
        .STEP     (STEP),
        .DEAD_CYC (DEAD_CYC)
    ) u_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .estop   (estop),
        .tgt     (rght_tgt),
        .duty    (rght_duty),
        .settled (rght_settled)
    );

endmodule

// File: tb/tb_duty_slew.sv
// tb/tb_duty_slew.sv - directed self-checking bench for duty_slew
module tb_duty_slew;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_tgt;
    logic [11:0] rght_tgt;
    logic        estop;
    logic [11:0] lft_duty;
    logic [11:0] rght_duty;
    logic        lft_settled;
    logic        rght_settled;

    int n_run  = 0;
    int n_fail = 0;
    int edge_cnt;
    int n;
    logic seen_800;

    duty_slew #(
        .RAMP_DIV (4),
        .STEP     (8),
        .DEAD_CYC (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lft_tgt      (lft_tgt),
        .rght_tgt     (rght_tgt),
        .estop        (estop),
        .lft_duty     (lft_duty),
        .rght_duty    (rght_duty),
        .lft_settled  (lft_settled),
        .rght_settled (rght_settled)
    );

    always #5 clk = ~clk;

    // bench copy of the ramp timing: every 4th rising edge after reset release is a tick
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        do @(negedge clk); while (edge_cnt % 4 != 0);
    endtask

    function automatic int sd(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        rst_n    = 1'b0;
        estop    = 1'b0;
        lft_tgt  = 12'd0;
        rght_tgt = 12'd0;
        repeat (2) @(negedge clk);
        check("reset_lft_duty", sd(lft_duty), 0);
        check("reset_rght_duty", sd(rght_duty), 0);
        check("reset_lft_settled_tgt0", int'(lft_settled), 1);
        check("reset_rght_settled_tgt0", int'(rght_settled), 1);
        lft_tgt = 12'd20;
        #1;
        check("reset_lft_settled_tgt20", int'(lft_settled), 0);

        // ramp from reset, right held at +100 alongside
        @(negedge clk);
        rght_tgt = 12'd100;
        rst_n    = 1'b1;
        next_tick();
        check("ramp_t1", sd(lft_duty), 8);
        check("ramp_t1_unsettled", int'(lft_settled), 0);
        @(negedge clk);
        check("hold_between_ticks", sd(lft_duty), 8);
        next_tick();
        check("ramp_t2", sd(lft_duty), 16);
        next_tick();
        check("ramp_t3", sd(lft_duty), 20);
        check("ramp_t3_settled", int'(lft_settled), 1);

        // reversal +16 -> -16 with dead time; right keeps ramping
        lft_tgt = 12'd16;
        next_tick();
        check("down_to_16", sd(lft_duty), 16);
        lft_tgt = -12'sd16;
        next_tick();
        check("rev_8", sd(lft_duty), 8);
        next_tick();
        check("rev_0", sd(lft_duty), 0);
        check("rght_indep_t6", sd(rght_duty), 48);
        next_tick();
        check("dead_ignores_tick1", sd(lft_duty), 0);
        next_tick();
        check("dead_ignores_tick2", sd(lft_duty), 0);
        next_tick();
        check("rev_m8", sd(lft_duty), -8);
        next_tick();
        check("rev_m16", sd(lft_duty), -16);
        check("rght_indep_t10", sd(rght_duty), 80);

        // second reversal, target dropped to 0 inside DEAD: settled measures the dead length
        lft_tgt = 12'd16;
        next_tick();
        check("rev2_m8", sd(lft_duty), -8);
        next_tick();
        check("rev2_0", sd(lft_duty), 0);
        lft_tgt = 12'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (lft_settled) break;
            n++;
            @(negedge clk);
        end
        check("dead_clocks", n, 10);
        next_tick();
        check("rght_settled_100", sd(rght_duty), 100);
        check("rght_settled_flag", int'(rght_settled), 1);

        // right to -2048: clamped to -2047, never 0x800
        rght_tgt = 12'h800;
        seen_800 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            next_tick();
            if (rght_duty == 12'h800) seen_800 = 1'b1;
            if (rght_settled) break;
        end
        check("clamp_never_800", int'(seen_800), 0);
        check("clamp_final", sd(rght_duty), -2047);
        check("clamp_settled", int'(rght_settled), 1);
        check("lft_quiet", sd(lft_duty), 0);

        // ramp left to +400, then estop coincident with a tick
        lft_tgt = 12'd400;
        for (int i = 0; i < 80; i++) begin
            next_tick();
            if (lft_settled) break;
        end
        check("ramp_400", sd(lft_duty), 400);
        do @(negedge clk); while (edge_cnt % 4 != 3);
        estop   = 1'b1;
        lft_tgt = 12'd800;
        @(negedge clk);
        estop = 1'b0;
        check("estop_lft_0", sd(lft_duty), 0);
        check("estop_rght_0", sd(rght_duty), 0);
        next_tick();
        check("estop_reramp_8", sd(lft_duty), 8);
        check("estop_rght_m8", sd(rght_duty), -8);
        next_tick();
        check("estop_reramp_16", sd(lft_duty), 16);

        // reset in DEAD abandons the reversal
        lft_tgt = -12'sd16;
        next_tick();
        check("rst_rev_8", sd(lft_duty), 8);
        next_tick();
        check("rst_rev_0", sd(lft_duty), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_rght", sd(rght_duty), 0);
        check("rst_async_lft", sd(lft_duty), 0);
        lft_tgt  = 12'd8;
        rght_tgt = 12'd0;
        #1;
        check("rst_lft_settled_tgt8", int'(lft_settled), 0);
        check("rst_rght_settled_tgt0", int'(rght_settled), 1);
        @(negedge clk);
        rst_n = 1'b1;
        next_tick();
        check("rst_no_dead_8", sd(lft_duty), 8);
        check("rst_no_dead_settled", int'(lft_settled), 1);

        // target 0 never enters DEAD; a following negative target ramps directly
        lft_tgt = 12'd0;
        next_tick();
        check("zero_tgt_duty", sd(lft_duty), 0);
        check("zero_tgt_settled", int'(lft_settled), 1);
        @(negedge clk);
        check("zero_tgt_still_settled", int'(lft_settled), 1);
        lft_tgt = -12'sd8;
        next_tick();
        check("zero_then_neg", sd(lft_duty), -8);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/duty_slew.md
DUTY_SLEW -- requirements
Module: duty_slew

Interface
REQ-001 The module SHALL have parameter RAMP_DIV, default 64, meaning clocks per ramp tick (range 2..4096).
REQ-002 The module SHALL have parameter STEP, default 8, meaning maximum duty change per tick (range 1..2047).
REQ-003 The module SHALL have parameter DEAD_CYC, default 256, meaning clocks held at zero on a direction reversal (range 1..65535).
REQ-004 The module SHALL have port clk, input, 1 bit, meaning the system clock; all state updates on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, meaning an asynchronous active-low reset.
REQ-006 The module SHALL have port lft_tgt, input, 12 bits, meaning the signed two's-complement target duty for the left wheel.
REQ-007 The module SHALL have port rght_tgt, input, 12 bits, meaning the signed two's-complement target duty for the right wheel.
REQ-008 The module SHALL have port estop, input, 1 bit, meaning a synchronous emergency stop, active high.
REQ-009 The module SHALL have port lft_duty, output, 12 bits, meaning the signed slewed duty; it feeds the motor-driver stage.
REQ-010 The module SHALL have port rght_duty, output, 12 bits, meaning the signed slewed duty; it feeds the motor-driver stage.
REQ-011 The module SHALL have ports lft_settled and rght_settled, output, 1 bit each, meaning the channel duty equals its clamped target and the channel is in TRACK.

Function
REQ-012 Targets SHALL be clamped: -2048 maps to -2047; all other values pass unchanged, so an output never equals -2048.
REQ-013 One shared prescaler SHALL count 0..RAMP_DIV-1 and wrap; a tick is the cycle in which the count equals RAMP_DIV-1.
REQ-014 Each channel SHALL be an FSM with states TRACK and DEAD, and SHALL reset to TRACK.
REQ-015 In TRACK, on a tick, the channel SHALL take the effective target as 0 when the current duty is nonzero and has the opposite sign to the clamped target; otherwise the effective target is the clamped target.
REQ-016 On a tick, the current duty SHALL move toward the effective target by min(STEP, |difference|), with no overshoot.
REQ-017 Arithmetic SHALL use at least 13-bit signed intermediates so that no step wraps.
REQ-018 With no tick, the current duty SHALL hold.
REQ-019 If a step brings a nonzero duty to 0 while the clamped target is nonzero and of the opposite sign, the next state SHALL be DEAD and the dead counter SHALL load DEAD_CYC-1.
REQ-020 In DEAD, the duty SHALL hold at 0 and the counter SHALL decrement every clock, ignoring ticks.
REQ-021 In DEAD, the channel SHALL return to TRACK in the cycle after the counter reaches 0, then resume ramping on the next tick.
REQ-022 A target changing during DEAD SHALL not shorten the dead time.
REQ-023 A target that returns to the original sign during DEAD SHALL not shorten the dead time either.
REQ-024 A target of 0 SHALL never cause DEAD.
REQ-025 The two channels SHALL be fully independent apart from the shared prescaler.
REQ-026 While estop=1, the next-clock duty SHALL be 0 on both channels, state SHALL be TRACK, and the dead counters SHALL be cleared.
REQ-027 Estop SHALL override a tick occurring in the same cycle.
REQ-028 The prescaler SHALL keep running during estop.
REQ-029 Outputs SHALL be registered; a tick at cycle N SHALL be visible on lft_duty/rght_duty at cycle N+1.
REQ-030 The settled outputs SHALL be combinational from the registered duty and the clamped target.

Reset
REQ-031 On rst_n=0, lft_duty and rght_duty SHALL be 0, the prescaler SHALL be 0, the dead counters SHALL be 0, and the states SHALL be TRACK, all asynchronously.
REQ-032 The settled outputs SHALL be 1 during reset if the target is 0, and 0 otherwise.
REQ-033 Reset asserted mid-ramp or during DEAD SHALL abandon the operation; no reversal state SHALL survive reset.

Structure
REQ-034 A shared package SHALL hold the channel state enum (TRACK, DEAD), the DUTY_MAX=2047 constant and the DUTY_MIN=-2047 constant.
REQ-035 One sub-module, duty_ramp_ch, SHALL implement the per-channel FSM, step and clamp logic.
REQ-036 duty_slew SHALL instantiate duty_ramp_ch twice and own the prescaler.

Verification
REQ-037 The bench SHALL cover: STEP=8, RAMP_DIV=4, lft_tgt=20 from reset -> lft_duty 8, 16, 20 on successive ticks, then lft_settled=1.
REQ-038 The bench SHALL cover: duty=+16, target set to -16, DEAD_CYC=10 -> 8, then 0, then exactly 10 clocks at 0 in DEAD, then -8 and -16.
REQ-039 The bench SHALL cover: rght_tgt=-2048 -> rght_duty ramps and settles at -2047 (0x801), never 0x800.
REQ-040 The bench SHALL cover: estop pulsed for 1 cycle while duty=+400 and a tick is coincident -> duty 0 the next cycle, then re-ramps from 0.
REQ-041 The bench SHALL cover: rst_n asserted during DEAD -> outputs 0 immediately; after release with target +8, the first tick yields +8 with no dead time.
REQ-042 The bench SHALL cover: left reversal and right constant +100 simultaneously -> right is unaffected by the left DEAD state.
